// File: rtl/wdt_ctrl.sv
// Register front end for the watchdog core: turns bus writes into kick/load requests
// retried against the core's reject handshake. Define WDT_LOCK_EN to gate CTRL/WTOCNT writes.
module wdt_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reg_wr_en,
  input  logic             reg_rd_en,
  input  logic [4:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             reg_rd_valid,
  output logic             wden,
  output logic             wdlive,
  output logic [CNT_W-1:0] wtocnt,
  output logic             cnt_enable,
  input  logic             wdlive_reject,
  input  logic             cnt_enable_reject,
  input  logic             wto,
  output logic             irq
);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_KICK   = 3'd1;
  localparam logic [2:0] IDX_WTOCNT = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;

  localparam int unsigned CH_KICK = 0;
  localparam int unsigned CH_LOAD = 1;

  // Counter value on which WAIT gives up: the next increment would reach ACK_TIMEOUT.
  localparam int unsigned TO_CAP  = (ACK_TIMEOUT > 255) ? 255 : ACK_TIMEOUT;
  localparam logic [7:0]  TO_LAST = (TO_CAP == 0) ? 8'd0 : 8'(TO_CAP - 1);

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_PULSE,
    CH_WAIT
  } ch_state_e;

  logic [2:0]       word;
  logic             unused_addr_bits;
  logic             cfg_wr_ok;
  logic             lock_flag;
  logic             wr_ctrl, wr_kick, wr_cnt, wr_status;

  logic             wden_q, wden_d;
  logic             irq_en_q, irq_en_d;
  logic             sticky_q, sticky_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] wtocnt_q, wtocnt_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       err_q, err_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rd_valid_q;
  logic [31:0]      rd_mux;

  ch_state_e        st_q [2];
  ch_state_e        st_d [2];
  logic [7:0]       cnt_q [2];
  logic [7:0]       cnt_d [2];
  logic [1:0]       rej, pend_set, pend_clr, err_set, err_clr;

  assign word             = reg_addr[4:2];
  assign unused_addr_bits = ^reg_addr[1:0];

`ifdef WDT_LOCK_EN
  localparam logic [2:0]  IDX_LOCK = 3'd4;
  localparam logic [31:0] LOCK_KEY = 32'h5A5A_A5A5;

  logic unlock_q, unlock_d;

  // Any write consumes the unlock; only the key written to LOCK re-arms it.
  always_comb begin
    unlock_d = unlock_q;
    if (reg_wr_en) unlock_d = (word == IDX_LOCK) && (reg_wdata == LOCK_KEY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) unlock_q <= 1'b0;
    else     unlock_q <= unlock_d;
  end

  assign lock_flag = unlock_q;
  assign cfg_wr_ok = unlock_q;
`else
  assign lock_flag = 1'b0;
  assign cfg_wr_ok = 1'b1;
`endif

  assign wr_ctrl   = reg_wr_en && (word == IDX_CTRL) && cfg_wr_ok;
  assign wr_kick   = reg_wr_en && (word == IDX_KICK);
  assign wr_cnt    = reg_wr_en && (word == IDX_WTOCNT) && cfg_wr_ok;
  assign wr_status = reg_wr_en && (word == IDX_STATUS);

  assign rej      = {cnt_enable_reject, wdlive_reject};
  assign pend_set = {wr_cnt, wr_kick};
  assign err_clr  = {wr_status & reg_wdata[4], wr_status & reg_wdata[3]};

  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      st_d[c]     = st_q[c];
      cnt_d[c]    = cnt_q[c];
      pend_clr[c] = 1'b0;
      err_set[c]  = 1'b0;
      unique case (st_q[c])
        CH_IDLE: begin
          if (pend_q[c] && !rej[c]) st_d[c] = CH_PULSE;
        end
        CH_PULSE: begin
          pend_clr[c] = 1'b1;
          cnt_d[c]    = '0;
          st_d[c]     = CH_WAIT;
        end
        CH_WAIT: begin
          if ((cnt_q[c] != 8'd0) && !rej[c]) begin
            st_d[c] = CH_IDLE;
          end else if (cnt_q[c] >= TO_LAST) begin
            err_set[c] = 1'b1;
            st_d[c]    = CH_IDLE;
          end else begin
            cnt_d[c] = cnt_q[c] + 8'd1;
          end
        end
        default: st_d[c] = CH_IDLE;
      endcase
    end
  end

  // Set terms are OR-ed last so a same-cycle set beats the clear.
  always_comb begin
    pend_d   = (pend_q & ~pend_clr) | pend_set;
    err_d    = (err_q & ~err_clr) | err_set;
    sticky_d = wto | (sticky_q & ~(wr_status & reg_wdata[0]));
    wden_d   = wden_q | (wr_ctrl & reg_wdata[0]);
    irq_en_d = wr_ctrl ? reg_wdata[1] : irq_en_q;
    shadow_d = wr_cnt ? CNT_W'(reg_wdata) : shadow_q;
    wtocnt_d = wtocnt_q;
    if ((st_q[CH_LOAD] == CH_IDLE) && (st_d[CH_LOAD] == CH_PULSE)) wtocnt_d = shadow_q;
    irq_d    = sticky_d & irq_en_d;
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      IDX_CTRL:   rd_mux = {30'd0, irq_en_q, wden_q};
      IDX_WTOCNT: rd_mux = 32'(shadow_q);
      IDX_STATUS: rd_mux = {26'd0, lock_flag, err_q, pend_q, sticky_q};
      default:    rd_mux = '0;
    endcase
    rdata_d = reg_rd_en ? rd_mux : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wden_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      sticky_q   <= 1'b0;
      irq_q      <= 1'b0;
      shadow_q   <= '0;
      wtocnt_q   <= '0;
      pend_q     <= '0;
      err_q      <= '0;
      rdata_q    <= '0;
      rd_valid_q <= 1'b0;
      st_q[0]    <= CH_IDLE;
      st_q[1]    <= CH_IDLE;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      wden_q     <= wden_d;
      irq_en_q   <= irq_en_d;
      sticky_q   <= sticky_d;
      irq_q      <= irq_d;
      shadow_q   <= shadow_d;
      wtocnt_q   <= wtocnt_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= reg_rd_en;
      st_q[0]    <= st_d[0];
      st_q[1]    <= st_d[1];
      cnt_q[0]   <= cnt_d[0];
      cnt_q[1]   <= cnt_d[1];
    end
  end

  assign reg_rdata    = rdata_q;
  assign reg_rd_valid = rd_valid_q;
  assign wden         = wden_q;
  assign irq          = irq_q;
  assign wtocnt       = wtocnt_q;
  assign wdlive       = (st_q[CH_KICK] == CH_PULSE);
  assign cnt_enable   = (st_q[CH_LOAD] == CH_PULSE);

endmodule

// File: tb/tb_wdt_ctrl.sv
// Directed bench for wdt_ctrl: register map, channel handshake timing, sticky/irq, reset,
// and the WDT_LOCK_EN unlock sequence when that macro is defined.
module tb_wdt_ctrl;

  localparam logic [31:0] LOCK_KEY = 32'h5A5A_A5A5;
  localparam logic [4:0]  A_CTRL   = 5'h00;
  localparam logic [4:0]  A_KICK   = 5'h04;
  localparam logic [4:0]  A_WTOCNT = 5'h08;
  localparam logic [4:0]  A_STATUS = 5'h0C;
  localparam logic [4:0]  A_LOCK   = 5'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wr_en = 1'b0;
  logic        reg_rd_en = 1'b0;
  logic [4:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        reg_rd_valid;
  logic        wden, wdlive, cnt_enable, irq;
  logic [31:0] wtocnt;
  logic        wdlive_reject = 1'b0;
  logic        cnt_enable_reject = 1'b0;
  logic        wto = 1'b0;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_pulse;
  logic [31:0] rv;

  wdt_ctrl #(.CNT_W(32), .ACK_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rd_valid(reg_rd_valid),
    .wden(wden), .wdlive(wdlive), .wtocnt(wtocnt), .cnt_enable(cnt_enable),
    .wdlive_reject(wdlive_reject), .cnt_enable_reject(cnt_enable_reject),
    .wto(wto), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_wr_en = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    tick(1);
    reg_wr_en = 1'b0;
    reg_wdata = '0;
  endtask

  // LOCK write is ignored when the lock feature is absent, so timing is build-independent.
  task automatic wr_cfg(input logic [4:0] a, input logic [31:0] d);
    wr(A_LOCK, LOCK_KEY);
    wr(a, d);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    reg_rd_en = 1'b1;
    reg_addr  = a;
    tick(1);
    reg_rd_en = 1'b0;
    chk("rd_valid", 32'(reg_rd_valid), 32'd1);
    d = reg_rdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wden",     32'(wden), 32'd0);
    chk("rst_wdlive",   32'(wdlive), 32'd0);
    chk("rst_wtocnt",   wtocnt, 32'd0);
    chk("rst_cnt_en",   32'(cnt_enable), 32'd0);
    chk("rst_irq",      32'(irq), 32'd0);
    chk("rst_rd_valid", 32'(reg_rd_valid), 32'd0);
    chk("rst_rdata",    reg_rdata, 32'd0);
    rst = 1'b0;
    tick(1);
    rd(A_STATUS, rv);
    chk("rst_status", rv, 32'd0);

    wr(5'h14, 32'hFFFF_FFFF);
    rd(5'h14, rv);
    chk("rd_idx5", rv, 32'd0);
    rd(A_LOCK, rv);
    chk("rd_lock", rv, 32'd0);
    rd(5'h1C, rv);
    chk("rd_idx7", rv, 32'd0);

    // Load: pulse two cycles after the write
    wr_cfg(A_WTOCNT, 32'h100);
    chk("load_early", 32'(cnt_enable), 32'd0);
    tick(1);
    chk("load_pulse", 32'(cnt_enable), 32'd1);
    chk("load_value", wtocnt, 32'h100);
    tick(1);
    chk("load_end", 32'(cnt_enable), 32'd0);
    rd(A_STATUS, rv);
    chk("load_pend_clr", rv, 32'd0);
    chk("load_hold", wtocnt, 32'h100);
    tick(2);

    // Kick coalescing under reject
    wdlive_reject = 1'b1;
    wr(A_KICK, 32'd0);
    wr(A_KICK, 32'd1);
    wr(A_KICK, 32'd2);
    rd(5'h0E, rv);
    chk("kick_pend", rv, 32'h2);
    n_pulse = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_pulse += int'(wdlive);
    end
    chk("kick_held", 32'(n_pulse), 32'd0);
    wdlive_reject = 1'b0;
    chk("kick_rel0", 32'(wdlive), 32'd0);
    tick(1);
    chk("kick_pulse", 32'(wdlive), 32'd1);
    n_pulse = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      n_pulse += int'(wdlive);
    end
    chk("kick_single", 32'(n_pulse), 32'd0);
    rd(A_STATUS, rv);
    chk("kick_done", rv, 32'd0);

    // Kick written during its own PULSE cycle must refire once
    wr(A_KICK, 32'd0);
    chk("rekick_pre", 32'(wdlive), 32'd0);
    tick(1);
    chk("rekick_p1", 32'(wdlive), 32'd1);
    wr(A_KICK, 32'd0);
    chk("rekick_w0", 32'(wdlive), 32'd0);
    tick(1);
    chk("rekick_w1", 32'(wdlive), 32'd0);
    tick(1);
    chk("rekick_idle", 32'(wdlive), 32'd0);
    tick(1);
    chk("rekick_p2", 32'(wdlive), 32'd1);
    tick(1);
    chk("rekick_end", 32'(wdlive), 32'd0);
    tick(3);

    // Both channels released together pulse in the same cycle
    wdlive_reject = 1'b1;
    cnt_enable_reject = 1'b1;
    wr(A_KICK, 32'd0);
    wr_cfg(A_WTOCNT, 32'h123);
    tick(1);
    chk("dual_held", 32'({wdlive, cnt_enable}), 32'd0);
    wdlive_reject = 1'b0;
    cnt_enable_reject = 1'b0;
    tick(1);
    chk("dual_pulse", 32'({wdlive, cnt_enable}), 32'h3);
    chk("dual_value", wtocnt, 32'h123);
    tick(3);

    // Load timeout: reject stuck high after the pulse, a new shadow value queued in WAIT
    wr_cfg(A_WTOCNT, 32'h55);
    tick(1);
    chk("to_pulse", 32'(cnt_enable), 32'd1);
    chk("to_value", wtocnt, 32'h55);
    cnt_enable_reject = 1'b1;
    tick(1);
    wr_cfg(A_WTOCNT, 32'h66);
    chk("to_wait_val", wtocnt, 32'h55);
    chk("to_wait_en", 32'(cnt_enable), 32'd0);
    tick(252);
    rd(A_STATUS, rv);
    chk("to_before", rv, 32'h04);
    rd(A_STATUS, rv);
    chk("to_err", rv, 32'h14);
    chk("to_stable", wtocnt, 32'h55);
    chk("to_idle_en", 32'(cnt_enable), 32'd0);
    cnt_enable_reject = 1'b0;
    tick(1);
    chk("to_retry", 32'(cnt_enable), 32'd1);
    chk("to_new_val", wtocnt, 32'h66);
    tick(1);
    wr(A_STATUS, 32'h10);
    tick(1);
    rd(A_STATUS, rv);
    chk("to_err_clr", rv, 32'd0);

    // Sticky WTO and interrupt
    wr_cfg(A_CTRL, 32'h2);
    chk("irq_idle", 32'(irq), 32'd0);
    wto = 1'b1;
    tick(1);
    wto = 1'b0;
    chk("irq_set", 32'(irq), 32'd1);
    tick(1);
    chk("irq_hold", 32'(irq), 32'd1);
    wr(A_STATUS, 32'h1);
    chk("irq_clr", 32'(irq), 32'd0);
    wto = 1'b1;
    tick(1);
    chk("irq_set2", 32'(irq), 32'd1);
    wr(A_STATUS, 32'h1);
    chk("irq_setwins", 32'(irq), 32'd1);
    wto = 1'b0;
    rd(A_STATUS, rv);
    chk("sticky_rd", rv, 32'h1);
    wr(A_STATUS, 32'h1);
    chk("irq_clr2", 32'(irq), 32'd0);
    wr_cfg(A_CTRL, 32'h0);
    wto = 1'b1;
    tick(1);
    wto = 1'b0;
    tick(1);
    chk("irq_masked", 32'(irq), 32'd0);
    rd(A_STATUS, rv);
    chk("sticky_masked", rv, 32'h1);
    wr(A_STATUS, 32'h1);

    // WDEN write-1-sets and survives a later 0 write; async reset clears all
    chk("wden_init", 32'(wden), 32'd0);
    wr_cfg(A_CTRL, 32'h1);
    chk("wden_set", 32'(wden), 32'd1);
    wr_cfg(A_CTRL, 32'h0);
    chk("wden_sticky", 32'(wden), 32'd1);
    rd(A_CTRL, rv);
    chk("ctrl_rd", rv, 32'h1);
    tick(1);
    chk("rd_valid_pulse", 32'(reg_rd_valid), 32'd0);
    chk("rdata_hold", reg_rdata, 32'h1);
    wr_cfg(A_CTRL, 32'h3);
    wto = 1'b1;
    tick(1);
    wto = 1'b0;
    chk("pre_rst_irq", 32'(irq), 32'd1);
    chk("pre_rst_cnt", wtocnt, 32'h66);
    rst = 1'b1;
    #2;
    chk("arst_wden", 32'(wden), 32'd0);
    chk("arst_wtocnt", wtocnt, 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    rd(A_CTRL, rv);
    chk("post_rst_ctrl", rv, 32'd0);
    rd(A_STATUS, rv);
    chk("post_rst_status", rv, 32'd0);

`ifdef WDT_LOCK_EN
    wr(A_WTOCNT, 32'h20);
    tick(1);
    chk("lock_blk_p", 32'(cnt_enable), 32'd0);
    tick(1);
    chk("lock_blk_p2", 32'(cnt_enable), 32'd0);
    chk("lock_blk_val", wtocnt, 32'd0);
    wr(A_LOCK, LOCK_KEY);
    rd(A_STATUS, rv);
    chk("lock_flag_rd", rv, 32'h20);
    wr(A_WTOCNT, 32'h20);
    tick(1);
    chk("lock_ok_p", 32'(cnt_enable), 32'd1);
    chk("lock_ok_val", wtocnt, 32'h20);
    tick(3);
    wr(A_WTOCNT, 32'h30);
    tick(1);
    chk("lock_relock_p", 32'(cnt_enable), 32'd0);
    tick(1);
    chk("lock_relock_p2", 32'(cnt_enable), 32'd0);
    chk("lock_relock_val", wtocnt, 32'h20);
    wr(A_LOCK, LOCK_KEY);
    wr(A_KICK, 32'd0);
    wr(A_CTRL, 32'h1);
    chk("lock_consumed", 32'(wden), 32'd0);
    tick(3);
    rd(A_STATUS, rv);
    chk("lock_flag_clr", rv, 32'd0);
`else
    wr(A_LOCK, LOCK_KEY);
    rd(A_STATUS, rv);
    chk("nolock_status", rv, 32'd0);
    rd(A_LOCK, rv);
    chk("nolock_rd", rv, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wdt_ctrl.md
Name: wdt_ctrl

Overview:
- Bus-side register front end for the watchdog core, acting as the initiator of the core's WDEN / WDLIVE / WTOCNT / CNT_enable interface.
- Converts single-cycle register writes into pulses and held levels toward the core. Uses the core's reject outputs as a busy handshake: a request is held pending and retried until the core accepts it.
- Latches the core's WTO into a sticky status bit and drives an interrupt.
- Single clock domain; the core owns all crossing into the watchdog clock.

Parameters:
- CNT_W, 32, width of WTOCNT shadow and output.
- ACK_TIMEOUT, 255, max cycles a channel waits for reject to drop before flagging an error (8-bit counter, saturating).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- reg_wr_en  in  1  register write strobe, always accepted
- reg_rd_en  in  1  register read strobe
- reg_addr  in  5  byte address; word index = reg_addr[4:2]
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, valid when reg_rd_valid
- reg_rd_valid  out  1  one-cycle pulse, the cycle after reg_rd_en
- wden  out  1  watchdog enable level to core
- wdlive  out  1  one-cycle kick pulse to core
- wtocnt  out  CNT_W  timeout threshold to core, stable while a load is in flight
- cnt_enable  out  1  one-cycle load pulse for wtocnt
- wdlive_reject  in  1  core busy on kick channel
- cnt_enable_reject  in  1  core busy on load channel
- wto  in  1  core timeout level
- irq  out  1  interrupt

Behaviour:
- Reset values: all outputs 0. Shadow registers 0. Both channel FSMs in IDLE. Pending, error and sticky bits 0.
- Register map (word index):
  - 0 CTRL: bit0 WDEN, write-1-sets, sticky until rst (writing 0 is ignored); bit1 IRQ_EN, read/write.
  - 1 KICK: any write sets kick_pend.
  - 2 WTOCNT: write loads shadow[CNT_W-1:0] and sets load_pend.
  - 3 STATUS: bit0 WTO_STICKY, write-1-clears; bit1 kick_pend; bit2 load_pend; bit3 kick_err; bit4 load_err. Bits 3-4 are write-1-clear.
  - 4 LOCK: see Optional Feature.
  - Other indices read 0; writes to them are ignored.
- Read latency is 1 cycle. reg_rdata holds its last value when reg_rd_valid is low.
- wden is registered from CTRL.bit0 with 1-cycle latency from the write.
- Channel FSM, identical for the kick channel (kick_pend, wdlive, wdlive_reject) and the load channel (load_pend, cnt_enable, cnt_enable_reject):
  - IDLE: if pend and reject==0, go to PULSE.
  - PULSE: the output pulse is high for exactly this cycle; pend is cleared; timeout counter is zeroed; go to WAIT.
  - WAIT: stay at least 1 cycle. Return to IDLE on the first cycle reject==0 after that minimum. If the counter reaches ACK_TIMEOUT, set the channel's err bit and return to IDLE anyway.
- Load channel: on entering PULSE, wtocnt is updated from the shadow. wtocnt does not change in any other state.
- A WTOCNT write during WAIT updates the shadow and re-sets load_pend; the new value goes out on the next PULSE.
- Kicks coalesce: any number of KICK writes while pending or in flight produce a single additional pulse.
- A pend set in the same cycle the FSM clears it (PULSE) is kept set.
- The two channels are independent and may pulse in the same cycle.
- WTO_STICKY is set when wto==1. If set and clear occur in the same cycle, set wins.
- irq = WTO_STICKY & IRQ_EN, registered, 1-cycle latency.
- rst asserted mid-operation returns everything to reset values immediately. Pulses in flight are dropped.

Optional Feature:
- WDT_LOCK_EN defined: writes to CTRL and WTOCNT are ignored unless the unlock flag is set.
  - Writing 0x5A5AA5A5 to LOCK sets the flag.
  - The next write to any register clears the flag; it is consumed even if the write targets another register.
  - STATUS bit5 reads the flag.
  - KICK and STATUS writes are never locked.
- Undefined: LOCK reads 0, writes to it are ignored, and STATUS bit5 reads 0.

Test Plan:
- Write WTOCNT=0x100 with cnt_enable_reject=0 -> cnt_enable high for exactly 1 cycle, 2 cycles after the write; wtocnt=0x100 in that cycle; STATUS bit2=0 afterward.
- Hold wdlive_reject=1, write KICK 3 times, release after 10 cycles -> exactly one wdlive pulse, 1 cycle after release; STATUS bit1 =1 until the pulse.
- Hold cnt_enable_reject=1 permanently after a load pulse -> STATUS bit4=1 after 255 cycles in WAIT; FSM returns to IDLE.
- Set IRQ_EN, pulse wto for 1 cycle -> irq=1 one cycle later. Write STATUS=1 with wto low -> irq=0. Repeat with wto=1 during the clear -> irq stays 1.
- Write CTRL=1, then CTRL=0 -> wden=1 and stays 1. Assert rst -> wden=0, wtocnt=0, irq=0.
- With WDT_LOCK_EN: write WTOCNT=0x20 -> no cnt_enable. Write LOCK=0x5A5AA5A5, then WTOCNT=0x20 -> pulse with wtocnt=0x20. Write WTOCNT=0x30 -> ignored.
